// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative Booth multiplier, one recode/add/shift step per clock.
// Supports signed or unsigned operands per operation, selected with each start.
// Uses a start/ready/done handshake. The product is held until the next accepted start.
// Optional macro BOOTH_RADIX4_EN selects modified-Booth radix-4.
// That mode retires two bits per step. Without the macro the block is radix-2.
module booth_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

`ifdef BOOTH_RADIX4_EN
  // Two guard bits keep 2M representable for the most-negative operand.
  localparam int XW   = WIDTH + 2;
  localparam int LAST = WIDTH / 2;
`else
  // One guard bit keeps -M representable for the most-negative operand.
  localparam int XW   = WIDTH + 1;
  localparam int LAST = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [XW-1:0]   acc;
  logic [XW-1:0]   q;
  logic [XW-1:0]   m;
  logic            q_1;
  logic [CNT_W-1:0] count;

  logic [XW-1:0]   acc_next;
  logic [XW-1:0]   q_next;
  logic            q_1_next;
  logic [XW-1:0]   a_ext;
  logic [XW-1:0]   b_ext;

  assign a_ext = {{(XW-WIDTH){is_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{(XW-WIDTH){is_signed & b[WIDTH-1]}}, b};

`ifdef BOOTH_RADIX4_EN
  // Sum is computed two bits wider so acc +/- 2M cannot wrap before the shift.
  logic [XW+1:0] m_x;
  logic [XW+1:0] m_x2;
  logic [XW+1:0] pp;
  logic [XW+1:0] sum;

  // Radix-4 step: recode {Q1,Q0,q_1} into 0, +/-M or +/-2M, add, shift right by 2.
  always_comb begin
    m_x  = {{2{m[XW-1]}}, m};
    m_x2 = {m_x[XW:0], 1'b0};
    case ({q[1], q[0], q_1})
      3'b001, 3'b010: pp = m_x;
      3'b011:         pp = m_x2;
      3'b100:         pp = -m_x2;
      3'b101, 3'b110: pp = -m_x;
      default:        pp = '0;
    endcase
    sum      = {{2{acc[XW-1]}}, acc} + pp;
    acc_next = sum[XW+1:2];
    q_next   = {sum[1:0], q[XW-1:2]};
    q_1_next = q[1];
  end
`else
  logic [XW-1:0] sum;

  // Radix-2 step: recode {Q0,q_1} into 0 or +/-M, add, shift right by 1.
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    {acc_next, q_next, q_1_next} = {sum[XW-1], sum, q};
  end
`endif

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      product <= '0;
      count   <= '0;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      q_1     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc   <= '0;
            q_1   <= 1'b0;
            q     <= a_ext;
            m     <= b_ext;
            count <= '0;
            state <= RUN;
            ready <= 1'b0;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        RUN: begin
          acc   <= acc_next;
          q     <= q_next;
          q_1   <= q_1_next;
          count <= count + CNT_W'(1);
          if (count == LAST_CNT) begin
            // Low 2*WIDTH bits of {A,Q} hold the exact product; guard bits drop off.
`ifdef BOOTH_RADIX4_EN
            product <= {acc_next[WIDTH-3:0], q_next};
`else
            product <= {acc_next[WIDTH-2:0], q_next};
`endif
            done  <= 1'b1;
            state <= DONE;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
